// File: rtl/pcs_rx_pkg.sv
// Shared definitions for the RX PCS symbol aligner.
//   COMMA_RDN / COMMA_RDP : the two running-disparity forms of K28.5
//   lock_state_e          : symbol-lock FSM states
//   is_comma()            : true when a 10b symbol is either K28.5 form
package pcs_rx_pkg;

    localparam logic [9:0] COMMA_RDN = 10'h0FA;
    localparam logic [9:0] COMMA_RDP = 10'h305;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == COMMA_RDN) || (sym == COMMA_RDP);
    endfunction

endpackage

// File: rtl/pcs_rx_comma_scan.sv
// Combinational K28.5 search over every bit offset of the two-word window.
//   win_i : window bits that any offset can reach; MSB is the earliest bit.
//           Offset p examines win_i[W+SYM_W-2-p -: SYM_W].
//   hit_o : a comma was found at some offset 0..W-1
//   pc_o  : the lowest offset holding a comma (0 when hit_o=0)
module pcs_rx_comma_scan
    import pcs_rx_pkg::*;
#(
    parameter int SYM_W = 10,
    parameter int W     = 20
) (
    input  logic [W+SYM_W-2:0]     win_i,
    output logic                   hit_o,
    output logic [$clog2(W)-1:0]   pc_o
);

    localparam int OFF_W = $clog2(W);

    logic [W-1:0] match;

    for (genvar p = 0; p < W; p++) begin : g_cmp
        assign match[p] = is_comma(win_i[W+SYM_W-2-p -: SYM_W]);
    end

    // Walk from the highest offset down so the lowest match is the one kept.
    always_comb begin
        hit_o = 1'b0;
        pc_o  = '0;
        for (int p = W-1; p >= 0; p--) begin
            if (match[p]) begin
                hit_o = 1'b1;
                pc_o  = OFF_W'(p);
            end
        end
    end

endmodule

// File: rtl/pcs_rx_symbol_lock.sv
// Comma-based symbol/word aligner with hysteretic lock tracking.
// Collects NUM_SYM unaligned symbols per word, finds K28.5 at any bit offset,
// barrel-shifts so the comma lands in lane 0, and qualifies lock.
//   clk_i            word clock
//   rst_i            asynchronous reset, active high
//   data_in_i        raw collected bits, MSB earliest in time
//   data_in_valid_i  word present this cycle; advances the pipeline
//   data_out_o       aligned word, lane 0 = data_out_o[W-1 -: SYM_W]
//   data_out_valid_o data_out_o refreshed this cycle while locked
//   sym_offset_o     bit offset applied by the shifter
//   comma_det_o      pulse: comma seen on this advance
//   lock_o           symbol lock (RxValid)
//   lock_lost_o      one-cycle pulse when lock drops
module pcs_rx_symbol_lock
    import pcs_rx_pkg::*;
#(
    parameter int SYM_W     = 10,
    parameter int NUM_SYM   = 2,
    parameter int LOCK_CNT  = 3,
    parameter int MIS_LIMIT = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_SYM*SYM_W-1:0]            data_in_i,
    input  logic                                data_in_valid_i,
    output logic [NUM_SYM*SYM_W-1:0]            data_out_o,
    output logic                                data_out_valid_o,
    output logic [$clog2(NUM_SYM*SYM_W)-1:0]    sym_offset_o,
    output logic                                comma_det_o,
    output logic                                lock_o,
    output logic                                lock_lost_o
);

    localparam int W     = NUM_SYM * SYM_W;
    localparam int OFF_W = $clog2(W);
    localparam int CNT_W = $clog2(LOCK_CNT) + 1;
    localparam int MIS_W = $clog2(MIS_LIMIT) + 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);
    localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(MIS_LIMIT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    lock_state_e      state_q, state_d;
    logic [W-1:0]     prev_q, cur_q;
    logic [W-1:0]     data_out_q, data_out_d;
    logic             data_out_valid_q;
    logic [OFF_W-1:0] sym_offset_q, sym_offset_d;
    logic             comma_det_q;
    logic             lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MIS_W-1:0] mis_q, mis_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             adv;
    logic             hit;
    logic [OFF_W-1:0] pc;
    logic             aligned;
    logic             mis_end, tmo_end;

    assign adv = data_in_valid_i;

    // Only the top W+SYM_W-1 window bits can start or finish a scanned symbol.
    pcs_rx_comma_scan #(
        .SYM_W (SYM_W),
        .W     (W)
    ) u_scan (
        .win_i ({prev_q, cur_q[W-1 -: SYM_W-1]}),
        .hit_o (hit),
        .pc_o  (pc)
    );

    // A comma in any lane with the same symbol phase confirms the current
    // alignment (e.g. SKP ordered sets put commas in non-zero lanes).
    assign aligned = hit && ((int'(pc) % SYM_W) == (int'(sym_offset_q) % SYM_W));

    // Barrel shifter: take W bits starting sym_offset_q bits into the window.
    assign data_out_d = W'(({prev_q, cur_q} << sym_offset_q) >> W);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mis_d        = mis_q;
        tmo_d        = tmo_q;
        sym_offset_d = sym_offset_q;
        lock_lost_d  = 1'b0;
        mis_end      = 1'b0;
        tmo_end      = 1'b0;
        if (adv) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (hit) begin
                        sym_offset_d = pc;
                        cnt_d        = CNT_W'(1);
                        mis_d        = '0;
                        tmo_d        = '0;
                        state_d      = (LOCK_CNT == 1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (aligned) begin
                        tmo_d = '0;
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_LOCKED;
                            mis_d   = '0;
                        end
                    end else if (hit) begin
                        // Re-anchor on the new phase and restart qualification.
                        sym_offset_d = pc;
                        cnt_d        = CNT_W'(1);
                        tmo_d        = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_UNLOCKED;
                        cnt_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (aligned) begin
                        mis_d = '0;
                        tmo_d = '0;
                    end else begin
                        // Both limits are evaluated together so a coincident
                        // expiry produces a single loss event.
                        if (hit) begin
                            mis_end = (mis_q == MIS_LAST);
                            mis_d   = (mis_q == '1) ? mis_q : mis_q + MIS_W'(1);
                        end
                        tmo_end = (tmo_q == TMO_LAST);
                        tmo_d   = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
                        if (mis_end || tmo_end) begin
                            state_d     = ST_UNLOCKED;
                            lock_lost_d = 1'b1;
                            cnt_d       = '0;
                            mis_d       = '0;
                            tmo_d       = '0;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_UNLOCKED;
            prev_q           <= '0;
            cur_q            <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            sym_offset_q     <= '0;
            comma_det_q      <= 1'b0;
            lock_lost_q      <= 1'b0;
            cnt_q            <= '0;
            mis_q            <= '0;
            tmo_q            <= '0;
        end else begin
            state_q          <= state_d;
            sym_offset_q     <= sym_offset_d;
            cnt_q            <= cnt_d;
            mis_q            <= mis_d;
            tmo_q            <= tmo_d;
            lock_lost_q      <= lock_lost_d;
            comma_det_q      <= adv && hit;
            // Qualified with the post-update state so valid never shows
            // alongside a deasserted lock.
            data_out_valid_q <= adv && (state_d == ST_LOCKED);
            if (adv) begin
                prev_q     <= cur_q;
                cur_q      <= data_in_i;
                data_out_q <= data_out_d;
            end
        end
    end

    assign data_out_o       = data_out_q;
    assign data_out_valid_o = data_out_valid_q;
    assign sym_offset_o     = sym_offset_q;
    assign comma_det_o      = comma_det_q;
    assign lock_o           = (state_q == ST_LOCKED);
    assign lock_lost_o      = lock_lost_q;

endmodule

// File: tb/tb_pcs_rx_symbol_lock.sv
// Bench for pcs_rx_symbol_lock (NUM_SYM=2, W=20, LOCK_CNT=3, MIS_LIMIT=4,
// TIMEOUT=16). A behavioural model tracks the expected outputs; a compare
// process checks them every negedge, and directed scenarios add literal checks.
module tb_pcs_rx_symbol_lock;

    localparam int W        = 20;
    localparam int LOCKN    = 3;
    localparam int MISN     = 4;
    localparam int TMON     = 16;
    localparam logic [9:0] RDN = 10'h0FA;
    localparam logic [9:0] RDP = 10'h305;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] din;
    logic        dv;
    logic [19:0] dout;
    logic        dval;
    logic [4:0]  off;
    logic        cdet;
    logic        lock;
    logic        lost;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [19:0] m_prev = '0, m_cur = '0, m_dout = '0;
    bit          m_dval = 0, m_cdet = 0, m_lost = 0;
    bit          m_lock = 0, m_chk = 0;
    int          m_off = 0, m_cnt = 0, m_mis = 0, m_tmo = 0;

    pcs_rx_symbol_lock #(
        .SYM_W     (10),
        .NUM_SYM   (2),
        .LOCK_CNT  (LOCKN),
        .MIS_LIMIT (MISN),
        .TIMEOUT   (TMON)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .data_in_i        (din),
        .data_in_valid_i  (dv),
        .data_out_o       (dout),
        .data_out_valid_o (dval),
        .sym_offset_o     (off),
        .comma_det_o      (cdet),
        .lock_o           (lock),
        .lock_lost_o      (lost)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_cur = '0; m_dout = '0;
        m_dval = 0; m_cdet = 0; m_lost = 0;
        m_lock = 0; m_chk = 0;
        m_off = 0; m_cnt = 0; m_mis = 0; m_tmo = 0;
    endtask

    // One clock of the spec's rules, applied to the inputs seen at the edge.
    task automatic model_step();
        logic [39:0] win, sh;
        logic [9:0]  s;
        bit          hit, al;
        int          pc;
        if (rst) begin
            model_reset();
            return;
        end
        m_dval = 0; m_cdet = 0; m_lost = 0;
        if (!dv) return;
        win = {m_prev, m_cur};
        hit = 0; pc = 0;
        for (int p = 0; p < W; p++) begin
            s = 10'((win >> (30 - p)) & 40'h3FF);
            if (!hit && (s == RDN || s == RDP)) begin
                hit = 1;
                pc  = p;
            end
        end
        sh     = win << m_off;
        m_dout = sh[39:20];
        al     = hit && ((pc % 10) == (m_off % 10));
        if (m_lock) begin
            if (al) begin
                m_mis = 0; m_tmo = 0;
            end else begin
                if (hit) m_mis++;
                m_tmo++;
                if (m_mis >= MISN || m_tmo >= TMON) begin
                    m_lock = 0; m_lost = 1; m_mis = 0; m_tmo = 0; m_cnt = 0;
                end
            end
        end else if (m_chk) begin
            if (al) begin
                m_cnt++; m_tmo = 0;
                if (m_cnt >= LOCKN) begin
                    m_chk = 0; m_lock = 1; m_mis = 0;
                end
            end else if (hit) begin
                m_off = pc; m_cnt = 1; m_tmo = 0;
            end else begin
                m_tmo++;
                if (m_tmo >= TMON) begin
                    m_chk = 0; m_tmo = 0; m_cnt = 0;
                end
            end
        end else if (hit) begin
            m_off = pc; m_cnt = 1; m_mis = 0; m_tmo = 0;
            if (LOCKN == 1) m_lock = 1; else m_chk = 1;
        end
        m_cdet = hit;
        m_dval = m_lock;
        m_prev = m_cur;
        m_cur  = din;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [19:0] w);
        din = w;
        dv  = 1'b1;
        tick();
        dv  = 1'b0;
    endtask

    task automatic zeros(input int n);
        repeat (n) send('0);
    endtask

    task automatic idle(input int n);
        dv = 1'b0;
        repeat (n) tick();
    endtask

    // Two words carrying comma c at window offset p; it is detected on the
    // advance following the second word.
    task automatic pair(input int p, input logic [9:0] c);
        logic [39:0] v;
        v = 40'(c) << (30 - p);
        send(v[39:20]);
        send(v[19:0]);
    endtask

    initial forever begin
        @(negedge clk);
        check("cmp_dout", dout, m_dout);
        check("cmp_dval", dval, m_dval);
        check("cmp_off",  off,  m_off);
        check("cmp_cdet", cdet, m_cdet);
        check("cmp_lock", lock, m_lock);
        check("cmp_lost", lost, m_lost);
    end

    initial begin
        rst = 1'b1; dv = 1'b0; din = '0;
        model_reset();
        tick(); tick();
        check("rst_lock", lock, 0);
        check("rst_dout", dout, 0);
        check("rst_off",  off,  0);
        check("rst_dval", dval, 0);
        #1 rst = 1'b0;

        // 1: three p=7 commas, one every 4th word
        pair(7, RDN); zeros(1);
        check("t1_cdet1", cdet, 1);
        check("t1_off1",  off,  7);
        check("t1_dout1", dout, 20'h007D0);
        check("t1_lock1", lock, 0);
        zeros(1); pair(7, RDN); zeros(2); pair(7, RDN); zeros(1);
        check("t1_lock",  lock, 1);
        check("t1_off",   off,  7);
        check("t1_dout",  dout, 20'h3E800);
        check("t1_dval",  dval, 1);
        idle(1);
        check("t1_hold_dval", dval, 0);

        // 2: lane-1 commas (p=17) keep lock
        for (int i = 0; i < 3; i++) begin
            pair(17, RDN); zeros(1);
            check("t2_cdet", cdet, 1);
            check("t2_lock", lock, 1);
            zeros(1);
        end
        check("t2_off", off, 7);

        // 3: misaligned commas; an aligned one in between clears the count
        pair(3, RDN); zeros(1);
        check("t3_lock_m1", lock, 1);
        pair(17, RDN); zeros(1);
        for (int i = 0; i < 4; i++) begin
            pair(3, RDN); zeros(1);
            if (i < 3) check("t3_lock_hold", lock, 1);
        end
        check("t3_lost", lost, 1);
        check("t3_lock", lock, 0);
        check("t3_off_held", off, 7);
        zeros(1);
        check("t3_lost_pulse", lost, 0);
        pair(3, RDN); zeros(1);
        check("t3_reload_off", off, 3);
        check("t3_reload_lock", lock, 0);
        pair(3, RDN); zeros(1);
        pair(3, RDN); zeros(1);
        check("t3_relock", lock, 1);

        // 4: timeout after 16 comma-free words, then aligned comma on the 16th
        zeros(15);
        check("t4_lock_15", lock, 1);
        zeros(1);
        check("t4_lost", lost, 1);
        check("t4_unlock", lock, 0);
        for (int i = 0; i < 3; i++) begin
            pair(3, RDN); zeros(1);
        end
        check("t4_relock", lock, 1);
        zeros(13); pair(3, RDN); zeros(1);
        check("t4_save_lock", lock, 1);
        check("t4_save_lost", lost, 0);
        check("t4_save_cdet", cdet, 1);
        zeros(15);
        check("t4_lock_again", lock, 1);
        zeros(1);
        check("t4_lost2", lost, 1);

        // 5: CHECK cnt=2 re-anchored by a p=12 comma; hold freezes everything
        pair(7, RDN); zeros(1);
        pair(7, RDN); zeros(1);
        check("t5_off7", off, 7);
        check("t5_lock0", lock, 0);
        pair(12, RDN); zeros(1);
        check("t5_off12", off, 12);
        check("t5_cdet", cdet, 1);
        check("t5_nolock", lock, 0);
        pair(12, RDN); zeros(1);
        check("t5_cnt2_lock", lock, 0);
        pair(12, RDN); idle(5);
        check("t5_frz_dval", dval, 0);
        check("t5_frz_cdet", cdet, 0);
        check("t5_frz_off",  off,  12);
        check("t5_frz_lock", lock, 0);
        zeros(1);
        check("t5_lock", lock, 1);
        check("t5_dval", dval, 1);
        zeros(2);

        // 6: async reset mid-LOCKED, relock on RDP commas
        check("t6_pre_lock", lock, 1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("t6_rst_lock", lock, 0);
        check("t6_rst_off",  off,  0);
        check("t6_rst_dout", dout, 0);
        check("t6_rst_dval", dval, 0);
        check("t6_rst_cdet", cdet, 0);
        check("t6_rst_lost", lost, 0);
        tick();
        #2 rst = 1'b0;
        pair(5, RDP); zeros(1);
        check("t6_rdp_cdet", cdet, 1);
        check("t6_rdp_off",  off,  5);
        pair(5, RDP); zeros(1);
        check("t6_lock_2", lock, 0);
        pair(5, RDP); zeros(1);
        check("t6_lock_3", lock, 1);
        check("t6_off",    off,  5);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
